// File: rtl/regbus_arb_pkg.sv
// Shared types and helpers for the register-bus round-robin arbiter.
package regbus_arb_pkg;

   // Register-bus request with a 48-bit address and 32-bit data.
   typedef struct packed {
      logic [47:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_a48_d32_req_t;

   // Register-bus response with 32-bit data.
   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_a48_d32_rsp_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Width of a requester index, never below one bit.
   function automatic int unsigned calc_idx_width(input int unsigned num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Width of the watchdog counter, which must be able to hold TimeoutCycles.
   function automatic int unsigned calc_cnt_width(input int unsigned timeout_cycles);
      return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/regbus_arb_pick.sv
// Rotate-priority selector: first valid requester at or after the pointer.
module regbus_arb_pick
   import regbus_arb_pkg::*;
#(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned IdxWidth = calc_idx_width(NumReq)
) (
   input  logic [NumReq-1:0]   valid_i,
   input  logic [IdxWidth-1:0] rr_ptr_i,
   output logic [IdxWidth-1:0] idx_o,
   output logic                any_o
);

   // Scan offsets 0..NumReq-1 from the pointer and keep the first hit.
   always_comb begin
      int unsigned cand;
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int unsigned off = 0; off < NumReq; off++) begin
         cand = (32'(rr_ptr_i) + off) % NumReq;
         if (!any_o && valid_i[IdxWidth'(cand)]) begin
            any_o = 1'b1;
            idx_o = IdxWidth'(cand);
         end
      end
   end

endmodule

// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target among NumReq requesters,
// holding each grant until completion and aborting hung targets via a watchdog.
module regbus_rr_arbiter
   import regbus_arb_pkg::*;
#(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 256,
   parameter type         req_t         = reg_a48_d32_req_t,
   parameter type         rsp_t         = reg_a48_d32_rsp_t
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  req_t [NumReq-1:0]                     in_req_i,
   output rsp_t [NumReq-1:0]                     in_rsp_o,
   output req_t                                  out_req_o,
   input  rsp_t                                  out_rsp_i,
   output logic                                  busy_o,
   output logic [calc_idx_width(NumReq)-1:0]     grant_idx_o,
   output logic                                  timeout_o
);

   localparam int unsigned IdxWidth  = calc_idx_width(NumReq);
   localparam int unsigned CntWidth  = calc_cnt_width(TimeoutCycles);
   localparam int unsigned StrbWidth = DataWidth / 8;

   arb_state_e            state_q, state_d;
   logic [IdxWidth-1:0]   idx_q, idx_d;
   logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;

   logic [NumReq-1:0]     req_valid;
   logic [IdxWidth-1:0]   pick_idx;
   logic                  pick_any;
   logic [IdxWidth-1:0]   idx_inc;
   logic                  wd_expired;

   // Gather the valid bits for the selector.
   always_comb begin
      req_valid = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         req_valid[k] = in_req_i[k].valid;
      end
   end

   regbus_arb_pick #(
      .NumReq   (NumReq),
      .IdxWidth (IdxWidth)
   ) u_pick (
      .valid_i  (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   assign idx_inc    = (idx_q == IdxWidth'(NumReq - 1)) ? '0 : idx_q + IdxWidth'(1);
   assign wd_expired = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles - 1));

   // Next-state, pointer/counter update and request/response muxing.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      timeout_o = 1'b0;
      in_rsp_o  = '0;
      out_req_o.addr  = AddrWidth'(0);
      out_req_o.write = 1'b0;
      out_req_o.wdata = DataWidth'(0);
      out_req_o.wstrb = StrbWidth'(0);
      out_req_o.valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Grant is taken from registered state next cycle, so valid never
            // propagates combinationally from a requester to the target here.
            if (pick_any) begin
               state_d = BUSY;
               idx_d   = pick_idx;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            out_req_o       = in_req_i[idx_q];
            in_rsp_o[idx_q] = out_rsp_i;
            if (!in_req_i[idx_q].valid) begin
               // Requester abandoned the transfer: release without a response.
               state_d = IDLE;
            end else if (out_rsp_i.ready) begin
               // A real response beats a watchdog expiry in the same cycle.
               state_d  = IDLE;
               rr_ptr_d = idx_inc;
            end else if (wd_expired) begin
               out_req_o.valid       = 1'b0;
               in_rsp_o[idx_q].rdata = DataWidth'(0);
               in_rsp_o[idx_q].error = 1'b1;
               in_rsp_o[idx_q].ready = 1'b1;
               timeout_o             = 1'b1;
               state_d               = IDLE;
               rr_ptr_d              = idx_inc;
            end else if (cnt_q != CntWidth'(TimeoutCycles)) begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant index, pointer and watchdog registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy_o      = (state_q == BUSY);
   assign grant_idx_o = idx_q;

endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// Self-checking bench for regbus_rr_arbiter: table-driven arbitration vectors
// plus directed sequences for fairness, watchdog, race, reset and writes.
module tb_regbus_rr_arbiter;
   import regbus_arb_pkg::*;

   localparam int unsigned NumReq = 4;
   localparam int unsigned Tmo    = 4;

   typedef reg_a48_d32_req_t req_t;
   typedef reg_a48_d32_rsp_t rsp_t;

   typedef struct {
      logic [3:0]  mask;
      int unsigned exp_grant;
   } arb_vec_t;

   logic              clk = 1'b0;
   logic              rst;
   req_t [NumReq-1:0] in_req;
   rsp_t [NumReq-1:0] in_rsp;
   req_t              out_req;
   rsp_t              out_rsp;
   logic              busy;
   logic [1:0]        grant_idx;
   logic              timeout;

   logic              tgt_ready;
   logic [31:0]       tgt_rdata;
   logic [31:0]       mem [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regbus_rr_arbiter #(
      .NumReq        (NumReq),
      .AddrWidth     (48),
      .DataWidth     (32),
      .TimeoutCycles (Tmo),
      .req_t         (req_t),
      .rsp_t         (rsp_t)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_req_i    (in_req),
      .in_rsp_o    (in_rsp),
      .out_req_o   (out_req),
      .out_rsp_i   (out_rsp),
      .busy_o      (busy),
      .grant_idx_o (grant_idx),
      .timeout_o   (timeout)
   );

   // Target model: answers only while a grant is held, read data from tgt_rdata.
   always_comb begin
      out_rsp       = '0;
      out_rsp.ready = tgt_ready && busy;
      if (out_rsp.ready) out_rsp.rdata = tgt_rdata;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic req_t mk_read(input logic [47:0] addr);
      req_t r;
      r      = '0;
      r.addr = addr;
      return r;
   endfunction

   task automatic check_others_quiet(input string name, input int g);
      for (int k = 0; k < NumReq; k++) begin
         if (k != g) check($sformatf("%s rsp%0d quiet", name, k), 128'(in_rsp[k]), 128'(0));
      end
   endtask

   // Target-side byte-masked write of the accepted request.
   task automatic tgt_write();
      if (out_req.valid && out_rsp.ready && out_req.write) begin
         for (int b = 0; b < 4; b++) begin
            if (out_req.wstrb[b]) mem[out_req.addr[9:2]][b*8 +: 8] = out_req.wdata[b*8 +: 8];
         end
      end
   endtask

   initial begin
      arb_vec_t vecs [10];
      req_t     wr_req;
      int       g;

      // Pointer enters the table at 3 (after the single request to port 2).
      vecs[0] = '{4'b1111, 3};
      vecs[1] = '{4'b0110, 1};
      vecs[2] = '{4'b0011, 0};
      vecs[3] = '{4'b1000, 3};
      vecs[4] = '{4'b1001, 0};
      vecs[5] = '{4'b1001, 3};
      vecs[6] = '{4'b0100, 2};
      vecs[7] = '{4'b0011, 0};
      vecs[8] = '{4'b0010, 1};
      vecs[9] = '{4'b1010, 3};

      for (int i = 0; i < 256; i++) mem[i] = '0;
      rst       = 1'b1;
      in_req    = '0;
      tgt_ready = 1'b0;
      tgt_rdata = '0;

      // Reset state.
      #3;
      check("rst busy", 128'(busy), 128'(0));
      check("rst grant_idx", 128'(grant_idx), 128'(0));
      check("rst timeout", 128'(timeout), 128'(0));
      check("rst out_req", 128'(out_req), 128'(0));
      check("rst in_rsp", 128'(in_rsp), 128'(0));
      next_cycle();
      next_cycle();
      @(negedge clk);
      rst = 1'b0;
      next_cycle();

      // Single request: port 2 reads 0x100, target ready in the first BUSY cycle.
      tgt_ready = 1'b1;
      tgt_rdata = 32'h0000_CAFE;
      in_req[2] = mk_read(48'h100);
      in_req[2].valid = 1'b1;
      #1;
      check("single idle busy", 128'(busy), 128'(0));
      check("single no comb valid", 128'(out_req.valid), 128'(0));
      next_cycle();
      check("single busy", 128'(busy), 128'(1));
      check("single grant", 128'(grant_idx), 128'(2));
      check("single out valid", 128'(out_req.valid), 128'(1));
      check("single out addr", 128'(out_req.addr), 128'(48'h100));
      check("single rsp2", 128'(in_rsp[2]), 128'({32'h0000_CAFE, 1'b0, 1'b1}));
      check_others_quiet("single", 2);
      next_cycle();
      check("single back idle", 128'(busy), 128'(0));
      in_req = '0;

      // Table-driven arbitration vectors, one transaction each.
      for (int v = 0; v < 10; v++) begin
         for (int k = 0; k < NumReq; k++) begin
            in_req[k]       = mk_read(48'h200 + 48'(k * 16));
            in_req[k].valid = vecs[v].mask[k];
         end
         #1;
         check($sformatf("vec%0d idle busy", v), 128'(busy), 128'(0));
         check($sformatf("vec%0d idle out valid", v), 128'(out_req.valid), 128'(0));
         next_cycle();
         g = int'(vecs[v].exp_grant);
         check($sformatf("vec%0d grant", v), 128'(grant_idx), 128'(vecs[v].exp_grant));
         check($sformatf("vec%0d out addr", v), 128'(out_req.addr), 128'(48'h200 + 48'(g * 16)));
         check($sformatf("vec%0d rsp ready", v), 128'(in_rsp[g].ready), 128'(1));
         check_others_quiet($sformatf("vec%0d", v), g);
         next_cycle();
         in_req = '0;
      end

      // Fairness: all requesters continuously valid, pointer starts at 0.
      for (int k = 0; k < NumReq; k++) begin
         in_req[k]       = mk_read(48'h300 + 48'(k * 16));
         in_req[k].valid = 1'b1;
      end
      for (int t = 0; t < 8; t++) begin
         next_cycle();
         check($sformatf("fair%0d grant", t), 128'(grant_idx), 128'(t % 4));
         check($sformatf("fair%0d rsp ready", t), 128'(in_rsp[t % 4].ready), 128'(1));
         check_others_quiet($sformatf("fair%0d", t), t % 4);
         next_cycle();
         check($sformatf("fair%0d idle", t), 128'(busy), 128'(0));
      end
      in_req = '0;

      // Watchdog abort: target never ready, ports 1 and 2 waiting, pointer at 0.
      tgt_ready = 1'b0;
      in_req[1] = mk_read(48'h110);
      in_req[1].valid = 1'b1;
      in_req[2] = mk_read(48'h120);
      in_req[2].valid = 1'b1;
      next_cycle();
      check("tmo grant", 128'(grant_idx), 128'(1));
      for (int c = 1; c < 4; c++) begin
         check($sformatf("tmo c%0d timeout", c), 128'(timeout), 128'(0));
         check($sformatf("tmo c%0d rsp1", c), 128'(in_rsp[1]), 128'(0));
         check($sformatf("tmo c%0d out valid", c), 128'(out_req.valid), 128'(1));
         next_cycle();
      end
      check("tmo c4 timeout", 128'(timeout), 128'(1));
      check("tmo c4 rsp1", 128'(in_rsp[1]), 128'({32'h0, 1'b1, 1'b1}));
      check("tmo c4 out valid", 128'(out_req.valid), 128'(0));
      check_others_quiet("tmo c4", 1);
      next_cycle();
      check("tmo idle busy", 128'(busy), 128'(0));
      check("tmo idle pulse gone", 128'(timeout), 128'(0));
      in_req[1].valid = 1'b0;
      next_cycle();
      check("tmo next grant", 128'(grant_idx), 128'(2));
      tgt_ready = 1'b1;
      tgt_rdata = 32'h1111_2222;
      #1;
      check("tmo next rsp2", 128'(in_rsp[2]), 128'({32'h1111_2222, 1'b0, 1'b1}));
      next_cycle();
      in_req = '0;

      // Race: ready arrives in the same cycle the watchdog would fire; pointer at 3.
      tgt_ready = 1'b0;
      tgt_rdata = 32'h0000_BEEF;
      in_req[0] = mk_read(48'h100);
      in_req[0].valid = 1'b1;
      next_cycle();
      check("race grant", 128'(grant_idx), 128'(0));
      next_cycle();
      next_cycle();
      next_cycle();
      tgt_ready = 1'b1;
      #1;
      check("race rsp0", 128'(in_rsp[0]), 128'({32'h0000_BEEF, 1'b0, 1'b1}));
      check("race timeout", 128'(timeout), 128'(0));
      check("race out valid", 128'(out_req.valid), 128'(1));
      next_cycle();
      check("race idle", 128'(busy), 128'(0));
      in_req = '0;

      // Move pointer to 2 with a quick port-1 transaction (pointer at 1).
      in_req[1] = mk_read(48'h140);
      in_req[1].valid = 1'b1;
      next_cycle();
      check("pre-rst grant", 128'(grant_idx), 128'(1));
      next_cycle();
      in_req = '0;

      // Reset mid-transaction on port 3 while port 1 is pending.
      tgt_ready = 1'b0;
      in_req[3] = mk_read(48'h180);
      in_req[3].valid = 1'b1;
      next_cycle();
      check("mid grant", 128'(grant_idx), 128'(3));
      in_req[1] = mk_read(48'h144);
      in_req[1].valid = 1'b1;
      next_cycle();
      rst = 1'b1;
      #1;
      check("mid rst busy", 128'(busy), 128'(0));
      check("mid rst out_req", 128'(out_req), 128'(0));
      check("mid rst in_rsp", 128'(in_rsp), 128'(0));
      check("mid rst grant_idx", 128'(grant_idx), 128'(0));
      check("mid rst timeout", 128'(timeout), 128'(0));
      next_cycle();
      @(negedge clk);
      rst = 1'b0;
      next_cycle();
      check("post rst busy", 128'(busy), 128'(1));
      check("post rst grant", 128'(grant_idx), 128'(1));
      check("post rst out addr", 128'(out_req.addr), 128'(48'h144));
      tgt_ready = 1'b1;
      next_cycle();
      in_req = '0;

      // Write pass-through from port 3 with a sparse strobe; pointer at 2.
      mem[16]      = 32'hAABB_CCDD;
      wr_req       = '0;
      wr_req.addr  = 48'h40;
      wr_req.write = 1'b1;
      wr_req.wdata = 32'h1234_5678;
      wr_req.wstrb = 4'h5;
      wr_req.valid = 1'b1;
      in_req[3]    = wr_req;
      next_cycle();
      check("wr grant", 128'(grant_idx), 128'(3));
      check("wr out_req", 128'(out_req), 128'(wr_req));
      check("wr rsp3 ready", 128'(in_rsp[3].ready), 128'(1));
      tgt_write();
      next_cycle();
      in_req = '0;
      #1;
      check("wr idle out_req", 128'(out_req), 128'(0));
      check("wr mem", 128'(mem[16]), 128'(32'hAA34_CC78));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL sim_timeout: got no finish, expected finish before 100000");
      $fatal(1, "time bound expired");
   end

endmodule

// File: doc/regbus_rr_arbiter.md
# regbus_rr_arbiter

Round-robin arbiter that shares one register-bus target among `NumReq` requesters, e.g. the bootrom and clock-manager regbus ports of `occamy_top` plus debug or test masters, in front of a single `tb_memory_regbus` or peripheral. It serializes transactions and holds each grant until the target completes. A per-transaction watchdog converts a hung target into an error response so the granted requester is released.

## Interface
Parameters:
- `NumReq`, 4: number of requesters, at least 2.
- `AddrWidth`, 48: regbus address width.
- `DataWidth`, 32: regbus data width; `wstrb` is `DataWidth/8` bits.
- `TimeoutCycles`, 256: number of BUSY cycles before an abort; 0 disables the watchdog.
- `req_t`, `rsp_t`, `reg_a48_d32_req_t` / `reg_a48_d32_rsp_t`: regbus structs. `req_t` carries addr, write, wdata, wstrb, valid. `rsp_t` carries rdata, error, ready.

Ports:
- `clk_i` in 1: clock; the only clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `in_req_i` in `NumReq` x `req_t`: requester requests.
- `in_rsp_o` out `NumReq` x `rsp_t`: requester responses.
- `out_req_o` out `req_t`: request to the shared target.
- `out_rsp_i` in `rsp_t`: target response; `ready` may be combinational on `valid`.
- `busy_o` out 1: high while a grant is held (state BUSY).
- `grant_idx_o` out `$clog2(NumReq)`: index of the granted requester; valid while `busy_o`.
- `timeout_o` out 1: one-cycle pulse on a watchdog abort.

## Operation
- FSM states: IDLE and BUSY.
- IDLE:
  - `out_req_o.valid`=0. All `in_rsp_o` have ready=0, error=0, rdata=0.
  - If any `in_req_i[k].valid` is high, select the first valid index at or after `rr_ptr` (wrapping modulo `NumReq`). Register it as `idx`, clear the watchdog counter, and go to BUSY.
- BUSY:
  - `out_req_o` = `in_req_i[idx]` (all fields, including valid).
  - `in_rsp_o[idx]` = `out_rsp_i`. All other `in_rsp_o` stay zero.
  - Completion is `in_req_i[idx].valid && out_rsp_i.ready`. On completion: `rr_ptr <= (idx+1) mod NumReq`, go to IDLE.
  - Watchdog abort occurs when `TimeoutCycles`≠0, counter == `TimeoutCycles-1`, and ready=0. In that cycle:
    - `in_rsp_o[idx]` ready=1, error=1, rdata=0.
    - `out_req_o.valid` forced to 0.
    - `timeout_o`=1, `rr_ptr` advances, go to IDLE.
  - Requester drops valid while BUSY (protocol violation): go to IDLE with no response and no pointer advance.
  - Otherwise the counter increments and saturates.
- Simultaneous ready and watchdog expiry: ready wins, so the real response is passed through and `timeout_o` stays 0.
- Requests arriving during BUSY wait; they are never dropped or reordered within a requester.
- Reset values: state IDLE, `rr_ptr`=0, counter=0, `idx`=0. All outputs are 0: `out_req_o`, `in_rsp_o`, `busy_o`, `grant_idx_o`, `timeout_o`.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and asynchronously, and `out_req_o.valid` drops. Any in-flight transaction is lost and gets no response.

## Timing
- Grant latency: a request first seen in IDLE at cycle N is forwarded at cycle N+1. There is no combinational path from `in_req_i.valid` to `out_req_o.valid`.
- Response path from `out_rsp_i` to `in_rsp_o[idx]` is combinational (zero cycles).
- Best-case throughput: one transaction per 2 cycles (BUSY then IDLE).
- Abort: the error response appears in the `TimeoutCycles`-th BUSY cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NumReq-1,0. Worst-case wait is `NumReq-1` transactions.

## Structure
- Shared package `regbus_arb_pkg` holds:
  - the state enum `arb_state_e` {IDLE, BUSY};
  - the `IdxWidth`/`CntWidth` helper functions (`$clog2(NumReq)` and `$clog2(TimeoutCycles+1)`, each a minimum of 1).
- Sub-module `regbus_arb_pick`: combinational rotate-priority select. Inputs are the valid vector and `rr_ptr`; outputs are the chosen index and an `any` flag.
- The top level holds the FSM, the pointer, the watchdog counter and the muxing.

## Test plan
- Single request: req 2 reads addr 0x100; target ready on the 1st BUSY cycle with rdata 0xCAFE. Expected: `out_req_o.valid` at cycle 1, `in_rsp_o[2]` rdata 0xCAFE with ready=1 at cycle 1, IDLE at cycle 2, `rr_ptr`=3.
- Fairness: all 4 requesters valid continuously for 8 transactions, target always ready. Expected grant order 0,1,2,3,0,1,2,3, with no `in_rsp_o` asserted for non-granted ports.
- Timeout: `TimeoutCycles`=4, target never ready. Expected: error=1 and ready=1 to the requester and `timeout_o` pulse on the 4th BUSY cycle, then `out_req_o.valid`=0 and the next requester granted.
- Race: `TimeoutCycles`=4 and ready arrives on the 4th BUSY cycle. Expected: error equals `out_rsp_i.error` (0), `timeout_o`=0.
- Reset mid-op: assert `rst_i` during BUSY. Expected: all outputs 0 in that cycle; after release, a pending req 1 is granted with `rr_ptr` starting at 0.
- Write pass-through: req 3 writes wdata 0x12345678 with wstrb 0x5. Expected: `out_req_o` fields bit-identical and target memory updated only in bytes 0 and 2.
